// File: rtl/afe_spi_responder_if.sv
// AFE SPI responder bundle: SPI pins plus fabric write/read/status signals.
// slave = responder side, master = SPI master / fabric side.
interface afe_spi_responder_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  SPI_CLK;
  logic                  SPI_CSB;
  logic                  SPI_SDI;
  logic                  SPI_SDO;
  logic                  wrStrobe;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [7:0]            wrData;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [7:0]            rdData;
  logic [31:0]           status;

  modport slave (
    input  SPI_CLK, SPI_CSB, SPI_SDI, rdAddr,
    output SPI_SDO, wrStrobe, wrAddr, wrData, rdData, status
  );

  modport master (
    output SPI_CLK, SPI_CSB, SPI_SDI, rdAddr,
    input  SPI_SDO, wrStrobe, wrAddr, wrData, rdData, status
  );
endinterface

// File: rtl/afe_spi_responder.sv
// AFE SPI responder: oversampled mode-0 slave with 8-bit register file.
// Ports: clk, rst (sync high), bus (SPI pins, write/read port, status).
module afe_spi_responder #(
  parameter int FRAME_BITS = 24,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  afe_spi_responder_if.slave    bus
);

  localparam int HB    = FRAME_BITS - 8;
  localparam int CW    = $clog2(FRAME_BITS + 1);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] CNT_HDR = CW'(HB);
  localparam logic [CW-1:0] CNT_END = CW'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  state_t state, state_n;

  logic [1:0] csb_sy, sclk_sy, sdi_sy;
  logic       csb_q, sclk_q;
  logic [1:0] vld;
  logic       armed;

  logic [CW-1:0]         cnt, cnt_n;
  logic [FRAME_BITS-1:0] sr, sr_n;
  logic                  ovr;
  logic                  rd_frame;
  logic [7:0]            rd_byte;
  logic                  sdo;
  logic                  wr_stb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic [7:0]            rd_data;
  logic [15:0]           frm_cnt, err_cnt;
  logic [7:0]            mem [DEPTH];

  logic csb, sclk, sdi;
  logic csb_fall, csb_rise, sclk_rise;
  logic start, shift, ovr_set, ok, err;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [7:0]            lookup;

  assign csb  = csb_sy[1];
  assign sclk = sclk_sy[1];
  assign sdi  = sdi_sy[1];

  // A low CSB left over from reset must not open a frame: arm only
  // after a post-reset sample has shown CSB high.
  assign csb_fall  = armed & csb_q & ~csb;
  assign csb_rise  = ~csb_q & csb;
  assign sclk_rise = sclk & ~sclk_q;

  assign cnt_n    = cnt + 1'b1;
  assign sr_n     = {sr[FRAME_BITS-2:0], sdi};
  assign hdr_addr = sr_n[ADDR_WIDTH-1:0];
  assign lookup   = mem[hdr_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      csb_sy  <= 2'b11;
      sclk_sy <= 2'b00;
      sdi_sy  <= 2'b00;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      vld     <= 2'b00;
      armed   <= 1'b0;
    end else begin
      csb_sy  <= {csb_sy[0], bus.SPI_CSB};
      sclk_sy <= {sclk_sy[0], bus.SPI_CLK};
      sdi_sy  <= {sdi_sy[0], bus.SPI_SDI};
      csb_q   <= csb;
      sclk_q  <= sclk;
      vld     <= {vld[0], 1'b1};
      if (vld[1] && csb)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    shift   = 1'b0;
    ovr_set = 1'b0;
    ok      = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (csb_fall) begin
          state_n = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (csb_rise) begin
          state_n = IDLE;
          err     = 1'b1;
        end else if (sclk_rise) begin
          shift = 1'b1;
          if (cnt_n == CNT_END)
            state_n = TAIL;
        end
      end
      TAIL: begin
        if (csb_rise) begin
          state_n = IDLE;
          ok      = ~ovr;
          err     = ovr;
        end else if (sclk_rise) begin
          ovr_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sr       <= '0;
      ovr      <= 1'b0;
      rd_frame <= 1'b0;
      rd_byte  <= '0;
      sdo      <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_data  <= '0;
      frm_cnt  <= '0;
      err_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      wr_stb  <= 1'b0;
      rd_data <= mem[bus.rdAddr];
      if (start) begin
        cnt      <= '0;
        sr       <= '0;
        ovr      <= 1'b0;
        rd_frame <= 1'b0;
        rd_byte  <= '0;
        sdo      <= 1'b0;
      end
      if (shift) begin
        sr  <= sr_n;
        cnt <= cnt_n;
        // Header just completed on a read: present MSB now, the
        // remaining bits shift out on the following rises.
        if (cnt_n == CNT_HDR && sr_n[HB-1]) begin
          rd_frame <= 1'b1;
          sdo      <= lookup[7];
          rd_byte  <= {lookup[6:0], 1'b0};
        end else if (rd_frame && cnt_n < CNT_END) begin
          sdo     <= rd_byte[7];
          rd_byte <= {rd_byte[6:0], 1'b0};
        end else begin
          sdo <= 1'b0;
        end
      end
      if (ovr_set)
        ovr <= 1'b1;
      if (ok) begin
        frm_cnt <= frm_cnt + 1'b1;
        if (!sr[FRAME_BITS-1]) begin
          mem[sr[8 +: ADDR_WIDTH]] <= sr[7:0];
          wr_stb  <= 1'b1;
          wr_addr <= sr[8 +: ADDR_WIDTH];
          wr_data <= sr[7:0];
        end
      end
      if (err)
        err_cnt <= err_cnt + 1'b1;
      if (ok || err) begin
        sdo      <= 1'b0;
        rd_frame <= 1'b0;
      end
    end
  end

  assign bus.SPI_SDO  = sdo;
  assign bus.wrStrobe = wr_stb;
  assign bus.wrAddr   = wr_addr;
  assign bus.wrData   = wr_data;
  assign bus.rdData   = rd_data;
  assign bus.status   = {err_cnt, frm_cnt};

endmodule

// File: doc/afe_spi_responder.md
# afe_spi_responder

SPI responder (slave) for the analog front end SPI link, i.e. the device end of the link driven by the AFE SPI master. It oversamples SPI_CLK/SPI_CSB/SPI_SDI in the fabric clock domain and decodes fixed-length frames carrying a read/write flag, address and 8-bit data. It holds an internal 8-bit register file, returns read data on SPI_SDO, and reports writes and statistics to fabric logic. It is used as an AFE device model in system benches and as an emulated AFE target on boards without the physical part.

## Interface
- FRAME_BITS, 24: frame length in bits, 16 or 24; header = FRAME_BITS-8 bits, data = 8 bits.
- ADDR_WIDTH, 7: register file address width; register file depth 2^ADDR_WIDTH x 8; ADDR_WIDTH ≤ FRAME_BITS-9.
- clk  in  1  fabric clock; one clock domain; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- SPI_CLK  in  1  SPI clock from master, asynchronous, idle low (mode 0).
- SPI_CSB  in  1  chip select, asynchronous, active low.
- SPI_SDI  in  1  master-to-responder data, MSB first.
- SPI_SDO  out  1  responder-to-master data.
- wrStrobe  out  1  one-cycle pulse on committed SPI write.
- wrAddr  out  ADDR_WIDTH  address of committed write, valid with wrStrobe, held until next write.
- wrData  out  8  data of committed write, same validity as wrAddr.
- rdAddr  in  ADDR_WIDTH  fabric-side register file read address.
- rdData  out  8  register file contents at rdAddr, registered, 1-cycle latency.
- status  out  32  {errorCount[15:0], frameCount[15:0]}.

## Operation
- Header layout: bit FRAME_BITS-1 = R/W (1 = read); address = header[ADDR_WIDTH-1:0] of bits FRAME_BITS-2..8; unused upper address bits ignored; bits 7..0 = data.
- Inputs pass through a 2-flop synchroniser, then one edge-detect register; all decisions use the synchronised values.
- States: IDLE (CSB high), SHIFT (CSB low, bitCount < FRAME_BITS), TAIL (CSB low, bitCount ≥ FRAME_BITS).
- CSB fall: bitCount <= 0, shift-in register cleared, SPI_SDO <= 0, IDLE -> SHIFT. A CSB fall and SCLK rise detected in the same cycle: the CSB fall wins and the SCLK edge is ignored.
- SCLK rise in SHIFT: shift in SDI (MSB first), bitCount += 1.
- SCLK rise completing header bit FRAME_BITS-8 with R/W = 1: SPI_SDO <= reg[addr][7] in that cycle (combinational register-file lookup on the just-completed header).
- Each following SCLK rise in a read: SPI_SDO shifts to the next lower data bit. The rise completing bit FRAME_BITS takes SPI_SDO <= 0.
- SPI_SDO is 0 throughout the header and for write frames.
- bitCount reaching FRAME_BITS: SHIFT -> TAIL. Further rises in TAIL set the overrun flag; bitCount saturates.
- SCLK falls are ignored. SCLK edges while CSB is high are ignored.
- CSB rise commits:
  - exactly FRAME_BITS rises, no overrun: frameCount += 1. On a write, reg[addr] <= data, wrStrobe = 1, and wrAddr/wrData update in that cycle.
  - otherwise (short frame or overrun): errorCount += 1, no register write, no wrStrobe.
- Every CSB rise returns the block to IDLE and sets SPI_SDO <= 0.
- Counters are 16 bits each and wrap modulo 2^16.
- Fabric read port: rdData <= reg[rdAddr] every cycle. If an SPI write to the same address commits in the same cycle, rdData returns the old value and the new value appears one cycle later.
- Reset values: SPI_SDO 0, wrStrobe 0, wrAddr 0, wrData 0, rdData 0, both counters 0, all registers 0, state IDLE. Synchroniser flops reset to CSB = 1, SCLK = 0, SDI = 0.
- Reset asserted mid-frame aborts the frame: no commit, no count. After reset the block waits for a fresh CSB fall; a CSB already low at reset release is not treated as a frame.

## Timing
- Pin-to-event latency: 3 clk cycles (2 synchroniser + 1 edge register). SPI_SDO updates 4 clk cycles after the SPI_CLK rising edge at the pin.
- The master samples SDO at its rising edge, so SDO changing after the rise is hold-safe.
- Constraints on the master:
  - SPI_CLK period ≥ 6 clk cycles, high and low times ≥ 2 clk cycles each.
  - CSB setup to first SCLK rise ≥ 2 clk cycles.
  - Last SCLK fall to CSB rise ≥ 2 clk cycles.
  - CSB high time between frames ≥ 3 clk cycles.
- The nominal link (100 MHz clk, 12.5 Mb/s, 8-cycle SCLK period) meets all of these.
- wrStrobe asserts 4 clk cycles after the CSB rise at the pin.

## Test plan
- Write, FRAME_BITS=24: frame 0x00_05_A5 (W, addr 5, data 0xA5) at 8-cycle SCLK -> one wrStrobe with wrAddr=5, wrData=0xA5; rdAddr=5 gives rdData=0xA5 one cycle later; frameCount=1.
- Read: preload addr 5 = 0xA5, then frame 0x80_05_00 -> master's captured low byte 0xA5; SPI_SDO = 0 during the header; no wrStrobe; frameCount increments.
- FRAME_BITS=16: frame 0x0312 -> reg[3]=0x12; read frame 0x8300 -> master captures 0x12.
- Error frames: 15 SCLK pulses -> no write, errorCount=1. 25 pulses -> no write, errorCount=2. frameCount unchanged in both cases.
- rst asserted at bit 10 of a write frame, master then completes the frame -> no wrStrobe, counters 0. The next full frame commits normally.
- Collision: SPI write to addr 5 commits while rdAddr=5 -> rdData shows the old value that cycle and the new value the next cycle. Also drive 65536 valid frames -> frameCount wraps to 0.
